// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the transfer-phase state type
// used by both the initiator and the slave side of the codebase.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns one command into one APB transfer (SETUP then ACCESS)
// and returns a single registered response pulse, with optional wait-state abort.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the TIMEOUT-th ACCESS cycle that sees pready low.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;

  apb_state_e        state, state_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              wait_last;

  logic              pwrite_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_slverr_d;
  logic              rsp_timeout_d;

  assign cmd_ready = (state == IDLE);
  assign wait_last = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    pwrite_d      = pwrite;
    addr_d        = addr;
    pwdata_d      = pwdata;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d   = cmd_write;
          addr_d     = cmd_addr;
          pwdata_d   = cmd_wdata;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = pslverr;
          rsp_rdata_d   = pwrite ? '0 : prdata;
          rsp_timeout_d = 1'b0;
        end else if (wait_last) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // psel/penable are registered from the next state so they align with state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      addr        <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      psel        <= (state_d != IDLE);
      penable     <= (state_d == ACCESS);
      pwrite      <= pwrite_d;
      addr        <= addr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a driver issues commands and pushes expected
// responses; a negedge monitor models the slave and checks every response.
module tb_apb_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .addr(addr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            wait_n;
    logic          serr;
    logic [DW-1:0] prd;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic          exp_to;
    int            exp_lat;
    int            exp_psel;
    int            exp_pen;
    int            acc_cyc;
  } txn_t;

  txn_t q[$];
  txn_t mt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int rsp_seen = 0;
  int psel_n = 0;
  int pen_n = 0;
  int acc_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Monitor + slave model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      acc_cnt = 0; psel_n = 0; pen_n = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
    end else begin
      if (rsp_valid) begin
        rsp_seen++;
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(q.size()), 32'd1);
        end else begin
          mt = q.pop_front();
          chk("rsp_rdata", rsp_rdata, mt.exp_rd);
          chk("rsp_slverr", 32'(rsp_slverr), 32'(mt.exp_err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(mt.exp_to));
          chk("latency", 32'(cyc - mt.acc_cyc), 32'(mt.exp_lat));
          chk("psel_cycles", 32'(psel_n), 32'(mt.exp_psel));
          chk("penable_cycles", 32'(pen_n), 32'(mt.exp_pen));
          chk("cmd_ready_at_rsp", 32'(cmd_ready), 32'd1);
        end
      end
      if (psel && q.size() > 0) begin
        chk("pwrite_stable", 32'(pwrite), 32'(q[0].wr));
        chk("addr_stable", 32'(addr), 32'(q[0].a));
        chk("pwdata_stable", pwdata, q[0].wd);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      end
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && penable && q.size() > 0) begin
        pready  = (acc_cnt == q[0].wait_n);
        pslverr = pready ? q[0].serr : 1'b1;
        prdata  = pready ? q[0].prd : 32'hBAD0BAD0;
        acc_cnt++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = '0; acc_cnt = 0;
      end
      if (cmd_valid && cmd_ready) begin
        psel_n = 0; pen_n = 0;
      end
    end
  end

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int wn, input logic se, input logic [DW-1:0] prd,
                       input bit hold, input int gap);
    txn_t t;
    bit   got;
    bit   to;
    got = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_wait", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    to = (wn >= TO);
    t.wr = wr; t.a = a; t.wd = wd; t.wait_n = wn; t.serr = se; t.prd = prd;
    t.exp_to   = to;
    t.exp_err  = to ? 1'b1 : se;
    t.exp_rd   = (to || wr) ? '0 : prd;
    t.exp_lat  = to ? TO + 2 : wn + 3;
    t.exp_psel = to ? TO + 1 : wn + 2;
    t.exp_pen  = to ? TO : wn + 1;
    t.acc_cyc  = cyc;
    q.push_back(t);
    if (gap > 0) chk("accept_gap", 32'(cyc - last_acc), 32'(gap));
    last_acc = cyc;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  int seen_before;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_flags", {30'd0, rsp_slverr, rsp_timeout}, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 5'h03, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D, 1'b0, 0);
    drain();
    issue(1'b0, 5'h03, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    drain();
    issue(1'b0, 5'h1F, 32'h0, 0, 1'b1, 32'h12345678, 1'b0, 0);
    drain();
    issue(1'b0, 5'h07, 32'h0, 3, 1'b0, 32'h0BADF00D, 1'b0, 0);
    drain();
    issue(1'b0, 5'h11, 32'h0, 100, 1'b0, 32'h55AA55AA, 1'b0, 0);
    drain();
    chk("post_timeout_rdata_hold", rsp_rdata, 32'd0);
    chk("post_timeout_flag_hold", 32'(rsp_timeout), 32'd1);

    issue(1'b1, 5'h01, 32'h11111111, 0, 1'b0, 32'h0, 1'b1, 0);
    issue(1'b0, 5'h02, 32'h22222222, 0, 1'b0, 32'hA5A5A5A5, 1'b1, 3);
    issue(1'b1, 5'h04, 32'h44444444, 0, 1'b0, 32'h0, 1'b0, 3);
    drain();

    issue(1'b0, 5'h0A, 32'h0, 100, 1'b0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 20 && !penable; i++) begin
      @(posedge clk); #1;
    end
    chk("reset_setup_penable", 32'(penable), 32'd1);
    @(posedge clk); #2;
    seen_before = rsp_seen;
    resetn = 1'b0;
    q.delete();
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_addr", 32'(addr), 32'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_no_rsp", 32'(rsp_seen), 32'(seen_before));
    chk("post_rst_psel", 32'(psel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
